// File: rtl/exec_controller_pkg.sv
// rtl/exec_controller_pkg.sv - shared state codes and sizing defaults for the sequencer
package exec_controller_pkg;

    localparam int DEFAULT_DEPTH    = 16;
    localparam int DEFAULT_ADDR_W   = $clog2(DEFAULT_DEPTH);
    localparam int DEFAULT_TICK_DIV = 4;

    typedef enum logic [2:0] {
        ST_LOAD = 3'd0,
        ST_IDLE = 3'd1,
        ST_RUN  = 3'd2,
        ST_STEP = 3'd3,
        ST_HALT = 3'd4
    } state_e;

endpackage

// File: rtl/exec_controller_instr_buffer.sv
// rtl/exec_controller_instr_buffer.sv - DEPTH x 8 instruction store, sync write, async read
module instr_buffer #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data
);

    logic [7:0] mem [DEPTH];

    // Storage: cleared to zero by reset so an unloaded program reads as 8'h00.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read path is combinational so the core sees instruction[pc] in the same cycle.
    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/exec_controller.sv
// rtl/exec_controller.sv - run/step/halt/breakpoint sequencer issuing core_en strobes
module exec_controller
    import exec_controller_pkg::*;
#(
    parameter int DEPTH    = DEFAULT_DEPTH,
    parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load_valid,
    output logic       load_ready,
    input  logic [7:0] load_data,
    input  logic       load_req,
    input  logic       run_req,
    input  logic       step_req,
    input  logic       halt_req,
    input  logic       bp_en,
    input  logic [7:0] bp_addr,
    input  logic [7:0] core_pc,
    output logic [7:0] instruction,
    output logic       core_en,
    output logic [2:0] state,
    output logic       bp_hit
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int TICK_W = $clog2(TICK_DIV);

    state_e            state_q, state_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic              bp_mask_q, bp_mask_d;
    logic              core_en_q, core_en_d;
    logic              bp_hit_q, bp_hit_d;
    logic              wr_en;
    logic              tick_last;
    logic              bp_match;

    assign tick_last = (tick_q == TICK_W'(TICK_DIV - 1));
    assign bp_match  = bp_en && (core_pc == bp_addr) && !bp_mask_q;

    instr_buffer #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_instr_buffer (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr_q),
        .wr_data (load_data),
        .rd_addr (core_pc[ADDR_W-1:0]),
        .rd_data (instruction)
    );

    // State register: core_en is registered so the strobe is glitch-free for the core.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_LOAD;
            tick_q    <= '0;
            wr_ptr_q  <= '0;
            bp_mask_q <= 1'b0;
            core_en_q <= 1'b0;
            bp_hit_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            wr_ptr_q  <= wr_ptr_d;
            bp_mask_q <= bp_mask_d;
            core_en_q <= core_en_d;
            bp_hit_q  <= bp_hit_d;
        end
    end

    // Next-state logic: request priority is halt > load > step > run.
    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        wr_ptr_d  = wr_ptr_q;
        bp_mask_d = bp_mask_q;
        core_en_d = 1'b0;
        bp_hit_d  = bp_hit_q;
        wr_en     = 1'b0;
        case (state_q)
            ST_LOAD: begin
                if (load_valid) begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + ADDR_W'(1);
                    if (wr_ptr_q == ADDR_W'(DEPTH - 1)) begin
                        state_d = ST_IDLE;
                    end
                end
                if (run_req) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE, ST_HALT: begin
                if (halt_req) begin
                    state_d = ST_HALT;
                end else if (load_req) begin
                    state_d  = ST_LOAD;
                    wr_ptr_d = '0;
                end else if (step_req) begin
                    state_d   = ST_STEP;
                    core_en_d = 1'b1;
                    bp_hit_d  = 1'b0;
                end else if (run_req) begin
                    state_d   = ST_RUN;
                    tick_d    = '0;
                    bp_mask_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (halt_req) begin
                    state_d = ST_HALT;
                    tick_d  = '0;
                end else if (tick_last) begin
                    tick_d = '0;
                    if (bp_match) begin
                        state_d  = ST_HALT;
                        bp_hit_d = 1'b1;
                    end else begin
                        core_en_d = 1'b1;
                        bp_mask_d = 1'b0;
                    end
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            ST_STEP: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    assign load_ready = (state_q == ST_LOAD);
    assign core_en    = core_en_q;
    assign state      = state_q;
    assign bp_hit     = bp_hit_q;

endmodule

// File: tb/tb_exec_controller.sv
// tb/tb_exec_controller.sv - self-checking bench for exec_controller
module tb_exec_controller;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       load_valid;
    logic       load_ready;
    logic [7:0] load_data;
    logic       load_req;
    logic       run_req;
    logic       step_req;
    logic       halt_req;
    logic       bp_en;
    logic [7:0] bp_addr;
    logic [7:0] core_pc;
    logic [7:0] instruction;
    logic       core_en;
    logic [2:0] state;
    logic       bp_hit;

    logic       use_fixed;
    logic [7:0] fixed_pc;
    logic [7:0] sim_pc;
    logic       pc_clr;

    int n_pass  = 0;
    int n_total = 0;
    bit started = 1'b0;

    always #5 clk = ~clk;

    exec_controller dut (
        .clk         (clk),
        .reset       (reset),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_data   (load_data),
        .load_req    (load_req),
        .run_req     (run_req),
        .step_req    (step_req),
        .halt_req    (halt_req),
        .bp_en       (bp_en),
        .bp_addr     (bp_addr),
        .core_pc     (core_pc),
        .instruction (instruction),
        .core_en     (core_en),
        .state       (state),
        .bp_hit      (bp_hit)
    );

    assign core_pc = use_fixed ? fixed_pc : sim_pc;

    // Stand-in core: pc advances once per core_en strobe.
    always @(posedge clk or negedge reset) begin
        if (!reset)      sim_pc <= 8'd0;
        else if (pc_clr) sim_pc <= 8'd0;
        else if (core_en) sim_pc <= sim_pc + 8'd1;
    end

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: mode, program image, edges spent in RUN, expected strobe.
    int         m_state;
    logic [7:0] m_mem [16];
    int         m_wptr;
    int         m_edges;
    bit         m_first;
    bit         m_en;
    bit         m_bp;

    initial forever begin
        bit en_next;
        @(posedge clk or negedge reset);
        if (!reset) begin
            m_state = 0; m_wptr = 0; m_edges = 0; m_first = 0; m_en = 0; m_bp = 0;
            for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
        end else begin
            en_next = 0;
            case (m_state)
                0: begin
                    if (load_valid) begin
                        m_mem[m_wptr] = load_data;
                        m_wptr++;
                        if (m_wptr == 16) begin m_wptr = 0; m_state = 1; end
                    end
                    if (run_req) m_state = 1;
                end
                1, 4: begin
                    if (halt_req) m_state = 4;
                    else if (load_req) begin m_state = 0; m_wptr = 0; end
                    else if (step_req) begin m_state = 3; en_next = 1; m_bp = 0; end
                    else if (run_req) begin m_state = 2; m_edges = 0; m_first = 1; end
                end
                2: begin
                    if (halt_req) m_state = 4;
                    else begin
                        m_edges++;
                        if (m_edges % TD == 0) begin
                            if (bp_en && core_pc == bp_addr && !m_first) begin
                                m_state = 4; m_bp = 1;
                            end else begin
                                en_next = 1; m_first = 0;
                            end
                        end
                    end
                end
                3: m_state = 4;
                default: m_state = 0;
            endcase
            m_en = en_next;
        end
    end

    // Cycle compare against the model, sampled mid-cycle.
    logic prev_en = 1'b0;
    initial forever begin
        @(negedge clk);
        if (reset && started) begin
            check("state", int'(state), m_state);
            check("core_en", int'(core_en), int'(m_en));
            check("load_ready", int'(load_ready), int'(m_state == 0));
            check("bp_hit", int'(bp_hit), int'(m_bp));
            check("instruction", int'(instruction), int'(m_mem[core_pc[3:0]]));
            if (core_en) check("no_back_to_back", int'(prev_en), 0);
            prev_en = core_en;
        end else begin
            prev_en = 1'b0;
        end
    end

    initial begin
        int n;
        int pc0;
        reset = 1'b1; load_valid = 0; load_data = 0; load_req = 0; run_req = 0;
        step_req = 0; halt_req = 0; bp_en = 0; bp_addr = 0;
        use_fixed = 1; fixed_pc = 0; pc_clr = 0;
        #1 reset = 1'b0;
        #1;
        check("rst_state", int'(state), 0);
        check("rst_load_ready", int'(load_ready), 1);
        check("rst_core_en", int'(core_en), 0);
        check("rst_bp_hit", int'(bp_hit), 0);
        check("rst_instruction", int'(instruction), 0);
        @(posedge clk); #1 reset = 1'b1; started = 1'b1;

        // 1: load 16 words, buffer closes
        for (int i = 0; i < 16; i++) begin
            load_valid = 1; load_data = 8'(16 + i);
            tick();
        end
        load_valid = 0;
        check("t1_load_ready", int'(load_ready), 0);
        check("t1_state", int'(state), 1);
        fixed_pc = 8'd3;  #1 check("t1_instr_pc3", int'(instruction), 8'h13);
        fixed_pc = 8'd19; #1 check("t1_instr_pc19", int'(instruction), 8'h13);
        fixed_pc = 8'd15; #1 check("t1_instr_pc15", int'(instruction), 8'h1F);
        fixed_pc = 8'd0; load_valid = 1; load_data = 8'hFF;
        tick();
        load_valid = 0;
        check("t1_ignored_write", int'(instruction), 8'h10);

        // 2: free run, one strobe per TD clocks
        use_fixed = 0;
        run_req = 1; tick(); run_req = 0;
        n = 0;
        repeat (40) begin
            tick();
            if (core_en) n++;
        end
        check("t2_strobes", n, 10);
        check("t2_pc", int'(core_pc), 9);
        halt_req = 1; tick(); halt_req = 0;
        check("t2_halt_state", int'(state), 4);
        check("t2_halt_pc", int'(core_pc), 10);

        // 3: breakpoint at pc 5, then resume off it
        pc_clr = 1; tick(); pc_clr = 0;
        bp_en = 1; bp_addr = 8'd5;
        run_req = 1; tick(); run_req = 0;
        for (int i = 0; i < 100 && state != 3'd4; i++) tick();
        check("t3_bp_state", int'(state), 4);
        check("t3_bp_pc", int'(core_pc), 5);
        check("t3_bp_hit", int'(bp_hit), 1);
        run_req = 1; tick(); run_req = 0;
        for (int i = 0; i < 20 && core_pc != 8'd6; i++) tick();
        check("t3_resume_pc", int'(core_pc), 6);
        check("t3_resume_state", int'(state), 2);
        for (int i = 0; i < 20 && core_pc != 8'd8; i++) tick();
        check("t3_continue_pc", int'(core_pc), 8);
        halt_req = 1; tick(); halt_req = 0;

        // 4: three single steps from HALT
        bp_en = 0;
        pc0 = int'(core_pc);
        for (int k = 0; k < 3; k++) begin
            step_req = 1; tick(); step_req = 0;
            check("t4_step_state", int'(state), 3);
            check("t4_step_en", int'(core_en), 1);
            tick();
            check("t4_back_halt", int'(state), 4);
            check("t4_en_low", int'(core_en), 0);
        end
        check("t4_pc_advance", int'(core_pc), pc0 + 3);
        check("t4_bp_cleared", int'(bp_hit), 0);

        // 5: partial reload, halt beats run, halt drops the due strobe
        load_req = 1; tick(); load_req = 0;
        check("t5_load_state", int'(state), 0);
        load_valid = 1; load_data = 8'hA0; tick();
        load_data = 8'hA1; tick();
        load_valid = 0;
        run_req = 1; tick(); run_req = 0;
        check("t5_early_idle", int'(state), 1);
        use_fixed = 1;
        fixed_pc = 8'd1; #1 check("t5_instr1", int'(instruction), 8'hA1);
        fixed_pc = 8'd2; #1 check("t5_instr2_kept", int'(instruction), 8'h12);
        use_fixed = 0;
        halt_req = 1; run_req = 1; tick(); halt_req = 0; run_req = 0;
        check("t5_halt_wins", int'(state), 4);
        run_req = 1; tick(); run_req = 0;
        repeat (3) tick();
        pc0 = int'(core_pc);
        halt_req = 1; tick(); halt_req = 0;
        check("t5_halt_state", int'(state), 4);
        check("t5_no_strobe", int'(core_en), 0);
        tick();
        check("t5_no_strobe_late", int'(core_en), 0);
        check("t5_pc_held", int'(core_pc), pc0);

        // 6: asynchronous reset in the middle of RUN
        run_req = 1; tick(); run_req = 0;
        for (int i = 0; i < 20 && !core_en; i++) tick();
        check("t6_strobe_seen", int'(core_en), 1);
        #2 reset = 1'b0;
        #1;
        check("t6_core_en", int'(core_en), 0);
        check("t6_state", int'(state), 0);
        check("t6_instr", int'(instruction), 0);
        check("t6_load_ready", int'(load_ready), 1);
        use_fixed = 1; fixed_pc = 8'd200;
        #1 check("t6_instr_pc200", int'(instruction), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
